// File: rtl/tlul_reg_bridge.sv
// TL-UL device port to simple register-bus bridge: one transaction in flight, IDLE/ACCESS/RESP FSM.
// Optional feature macro TLUL_REG_BRIDGE_TIMEOUT_EN bounds the ACCESS wait to TimeoutCycles.

package tlul_pkg;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    localparam tl_d_user_t TL_D_USER_DEFAULT = '{rsp_intg: 7'h0, data_intg: 7'h0};

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic [0:0]  d_sink;
        logic [31:0] d_data;
        tl_d_user_t  d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

module tlul_reg_bridge #(
    parameter int AW            = 8,
    parameter int TimeoutCycles = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  tlul_pkg::tl_h2d_t tl_i,
    output tlul_pkg::tl_d2h_t tl_o,
    output logic              reg_re_o,
    output logic              reg_we_o,
    output logic [AW-1:0]     reg_addr_o,
    output logic [31:0]       reg_wdata_o,
    output logic [3:0]        reg_be_o,
    input  logic [31:0]       reg_rdata_i,
    input  logic              reg_ready_i,
    input  logic              reg_error_i
);

    import tlul_pkg::*;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e state_reg, state_next;

    logic [2:0]    opcode_reg;
    logic [1:0]    size_reg;
    logic [7:0]    source_reg;
    logic [AW-1:2] addr_reg;
    logic [3:0]    mask_reg;
    logic [31:0]   wdata_reg;
    logic [31:0]   rdata_reg, rdata_next;
    logic          error_reg, error_next;

    logic accept;
    logic req_read;
    logic req_write;
    logic req_bad;
    logic is_read;
    logic timeout_hit;

    assign accept    = tl_i.a_valid && (state_reg == IDLE);
    assign req_read  = (tl_i.a_opcode == Get);
    assign req_write = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
    assign req_bad   = !(req_read || req_write) || (tl_i.a_address[1:0] != 2'b00)
                       || (tl_i.a_size == 2'd3);
    assign is_read   = (opcode_reg == Get);

`ifdef TLUL_REG_BRIDGE_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);

    logic [CntW-1:0] cnt_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_reg <= '0;
        end else if (accept) begin
            cnt_reg <= '0;
        end else if ((state_reg == ACCESS) && !reg_ready_i) begin
            cnt_reg <= cnt_reg + CntW'(1);
        end
    end

    // Fires on the wait cycle that brings the count to TimeoutCycles.
    assign timeout_hit = (state_reg == ACCESS) && !reg_ready_i
                         && (cnt_reg == CntW'(TimeoutCycles - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            rdata_reg <= '0;
            error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            rdata_reg <= rdata_next;
            error_reg <= error_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            opcode_reg <= '0;
            size_reg   <= '0;
            source_reg <= '0;
            addr_reg   <= '0;
            mask_reg   <= '0;
            wdata_reg  <= '0;
        end else if (accept) begin
            opcode_reg <= tl_i.a_opcode;
            size_reg   <= tl_i.a_size;
            source_reg <= tl_i.a_source;
            addr_reg   <= tl_i.a_address[AW-1:2];
            mask_reg   <= tl_i.a_mask;
            wdata_reg  <= tl_i.a_data;
        end
    end

    always_comb begin
        state_next = state_reg;
        rdata_next = rdata_reg;
        error_next = error_reg;
        unique case (state_reg)
            IDLE: begin
                if (tl_i.a_valid) begin
                    // Malformed requests skip the register block entirely.
                    state_next = req_bad ? RESP : ACCESS;
                    rdata_next = '0;
                    error_next = req_bad;
                end
            end
            ACCESS: begin
                if (reg_ready_i) begin
                    state_next = RESP;
                    rdata_next = is_read ? reg_rdata_i : 32'h0;
                    error_next = reg_error_i;
                end else if (timeout_hit) begin
                    state_next = RESP;
                    rdata_next = '0;
                    error_next = 1'b1;
                end
            end
            RESP: begin
                if (tl_i.d_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign reg_re_o    = (state_reg == ACCESS) && is_read;
    assign reg_we_o    = (state_reg == ACCESS) && !is_read;
    assign reg_addr_o  = {addr_reg, 2'b00};
    assign reg_wdata_o = wdata_reg;
    assign reg_be_o    = mask_reg;

    // a_ready is gated by reset so it reads 0 while held and 1 right after release.
    always_comb begin
        tl_o          = '0;
        tl_o.a_ready  = (state_reg == IDLE) && rst_ni;
        tl_o.d_valid  = (state_reg == RESP);
        tl_o.d_opcode = is_read ? AccessAckData : AccessAck;
        tl_o.d_param  = '0;
        tl_o.d_size   = size_reg;
        tl_o.d_source = source_reg;
        tl_o.d_sink   = '0;
        tl_o.d_data   = rdata_reg;
        tl_o.d_user   = TL_D_USER_DEFAULT;
        tl_o.d_error  = error_reg;
    end

    logic unused_tl;
    assign unused_tl = ^{tl_i.a_param, tl_i.a_address[31:AW]};

endmodule

// File: tb/tb_tlul_reg_bridge.sv
// Directed self-checking bench for tlul_reg_bridge: reads, writes, errors, backpressure, reset, timeout.
module tb_tlul_reg_bridge;

    import tlul_pkg::*;

    logic        clk_i;
    logic        rst_ni;
    tl_h2d_t     tl_h2d;
    tl_d2h_t     tl_d2h;
    logic        reg_re_o;
    logic        reg_we_o;
    logic [7:0]  reg_addr_o;
    logic [31:0] reg_wdata_o;
    logic [3:0]  reg_be_o;
    logic [31:0] reg_rdata_i;
    logic        reg_ready_i;
    logic        reg_error_i;

    int n_checks = 0;
    int n_fail   = 0;

    tlul_reg_bridge #(
        .AW            (8),
        .TimeoutCycles (16)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .tl_i        (tl_h2d),
        .tl_o        (tl_d2h),
        .reg_re_o    (reg_re_o),
        .reg_we_o    (reg_we_o),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_be_o    (reg_be_o),
        .reg_rdata_i (reg_rdata_i),
        .reg_ready_i (reg_ready_i),
        .reg_error_i (reg_error_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_req(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] size,
                             input logic [7:0] src, input logic [3:0] mask, input logic [31:0] data);
        tl_h2d.a_valid   = 1'b1;
        tl_h2d.a_opcode  = op;
        tl_h2d.a_param   = 3'h0;
        tl_h2d.a_size    = size;
        tl_h2d.a_source  = src;
        tl_h2d.a_address = addr;
        tl_h2d.a_mask    = mask;
        tl_h2d.a_data    = data;
    endtask

    task automatic test_reset();
        tick();
        tick();
        if (tl_d2h.a_ready !== 1'b0) begin $display("FAIL rst_a_ready: got %b want 0", tl_d2h.a_ready); n_fail++; end
        n_checks++;
        if (tl_d2h.d_valid !== 1'b0) begin $display("FAIL rst_d_valid: got %b want 0", tl_d2h.d_valid); n_fail++; end
        n_checks++;
        if ({reg_re_o, reg_we_o} !== 2'b00) begin $display("FAIL rst_strobes: got %b want 00", {reg_re_o, reg_we_o}); n_fail++; end
        n_checks++;
        if ({reg_addr_o, reg_wdata_o, tl_d2h.d_error} !== 41'h0) begin
            $display("FAIL rst_data: got addr %h wdata %h err %b want 0", reg_addr_o, reg_wdata_o, tl_d2h.d_error); n_fail++;
        end
        n_checks++;
        rst_ni = 1'b1;
        #1;
        if (tl_d2h.a_ready !== 1'b1) begin $display("FAIL rst_release_a_ready: got %b want 1", tl_d2h.a_ready); n_fail++; end
        n_checks++;
        $display("tx reset released a_ready=%b", tl_d2h.a_ready);
        tick();
    endtask

    task automatic test_read();
        reg_ready_i = 1'b1;
        reg_rdata_i = 32'hDEADBEEF;
        tl_h2d.d_ready = 1'b1;
        drive_req(Get, 32'h10, 2'd2, 8'h05, 4'hF, 32'h0);
        if (tl_d2h.a_ready !== 1'b1) begin $display("FAIL rd_a_ready_N: got %b want 1", tl_d2h.a_ready); n_fail++; end
        n_checks++;
        tick();
        tl_h2d.a_valid = 1'b0;
        if ({reg_re_o, reg_we_o} !== 2'b10) begin $display("FAIL rd_strobe_N1: got %b want 10", {reg_re_o, reg_we_o}); n_fail++; end
        n_checks++;
        if (reg_addr_o !== 8'h10) begin $display("FAIL rd_addr: got %h want 10", reg_addr_o); n_fail++; end
        n_checks++;
        if ({tl_d2h.d_valid, tl_d2h.a_ready} !== 2'b00) begin
            $display("FAIL rd_busy_N1: got d_valid/a_ready %b want 00", {tl_d2h.d_valid, tl_d2h.a_ready}); n_fail++;
        end
        n_checks++;
        tick();
        if (reg_re_o !== 1'b0) begin $display("FAIL rd_strobe_N2: got %b want 0", reg_re_o); n_fail++; end
        n_checks++;
        if ({tl_d2h.d_valid, tl_d2h.d_opcode, tl_d2h.d_error} !== 5'b1_001_0) begin
            $display("FAIL rd_resp_hdr: got v=%b op=%0d err=%b want v=1 op=1 err=0", tl_d2h.d_valid, tl_d2h.d_opcode, tl_d2h.d_error);
            n_fail++;
        end
        n_checks++;
        if (tl_d2h.d_data !== 32'hDEADBEEF) begin $display("FAIL rd_data: got %h want deadbeef", tl_d2h.d_data); n_fail++; end
        n_checks++;
        if ({tl_d2h.d_source, tl_d2h.d_size, tl_d2h.d_param, tl_d2h.d_sink} !== {8'h05, 2'd2, 3'd0, 1'b0}) begin
            $display("FAIL rd_echo: got src %h size %0d param %0d sink %0d want src 05 size 2 param 0 sink 0",
                     tl_d2h.d_source, tl_d2h.d_size, tl_d2h.d_param, tl_d2h.d_sink); n_fail++;
        end
        n_checks++;
        if (tl_d2h.d_user !== TL_D_USER_DEFAULT) begin $display("FAIL rd_user: got %h want %h", tl_d2h.d_user, TL_D_USER_DEFAULT); n_fail++; end
        n_checks++;
        $display("tx read addr=10 d_data=%h d_error=%b", tl_d2h.d_data, tl_d2h.d_error);
        tick();
        if ({tl_d2h.d_valid, tl_d2h.a_ready} !== 2'b01) begin
            $display("FAIL rd_idle_N3: got d_valid/a_ready %b want 01", {tl_d2h.d_valid, tl_d2h.a_ready}); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_write();
        reg_ready_i = 1'b0;
        reg_rdata_i = 32'h12345678;
        tl_h2d.d_ready = 1'b1;
        drive_req(PutPartialData, 32'h24, 2'd1, 8'h3C, 4'h3, 32'h0000A5A5);
        tick();
        tl_h2d.a_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if ({reg_we_o, reg_re_o} !== 2'b10) begin $display("FAIL wr_strobe_c%0d: got %b want 10", i, {reg_we_o, reg_re_o}); n_fail++; end
            n_checks++;
            if ({reg_addr_o, reg_be_o, reg_wdata_o} !== {8'h24, 4'h3, 32'h0000A5A5}) begin
                $display("FAIL wr_bus_c%0d: got addr %h be %h wdata %h want 24 3 0000a5a5", i, reg_addr_o, reg_be_o, reg_wdata_o);
                n_fail++;
            end
            n_checks++;
            if (tl_d2h.d_valid !== 1'b0) begin $display("FAIL wr_early_resp_c%0d: got %b want 0", i, tl_d2h.d_valid); n_fail++; end
            n_checks++;
            if (i == 3) reg_ready_i = 1'b1;
            tick();
        end
        if (reg_we_o !== 1'b0) begin $display("FAIL wr_strobe_drop: got %b want 0", reg_we_o); n_fail++; end
        n_checks++;
        if ({tl_d2h.d_valid, tl_d2h.d_opcode, tl_d2h.d_error, tl_d2h.d_source, tl_d2h.d_data} !== {1'b1, 3'd0, 1'b0, 8'h3C, 32'h0}) begin
            $display("FAIL wr_resp: got v=%b op=%0d err=%b src=%h data=%h want v=1 op=0 err=0 src=3c data=0",
                     tl_d2h.d_valid, tl_d2h.d_opcode, tl_d2h.d_error, tl_d2h.d_source, tl_d2h.d_data); n_fail++;
        end
        n_checks++;
        $display("tx write addr=24 be=3 src=%h d_error=%b", tl_d2h.d_source, tl_d2h.d_error);
        tick();
    endtask

    task automatic test_errors();
        logic [2:0]  ops   [3] = '{Get, 3'h7, Get};
        logic [31:0] addrs [3] = '{32'h13, 32'h20, 32'h20};
        logic [1:0]  sizes [3] = '{2'd2, 2'd2, 2'd3};
        logic [2:0]  dops  [3] = '{3'd1, 3'd0, 3'd1};
        reg_ready_i = 1'b1;
        reg_rdata_i = 32'hCAFEF00D;
        tl_h2d.d_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_req(ops[i], addrs[i], sizes[i], 8'h40 + 8'(i), 4'hF, 32'h0);
            tick();
            tl_h2d.a_valid = 1'b0;
            if ({reg_re_o, reg_we_o} !== 2'b00) begin $display("FAIL err%0d_strobe: got %b want 00", i, {reg_re_o, reg_we_o}); n_fail++; end
            n_checks++;
            if ({tl_d2h.d_valid, tl_d2h.d_error, tl_d2h.d_opcode, tl_d2h.d_data} !== {1'b1, 1'b1, dops[i], 32'h0}) begin
                $display("FAIL err%0d_resp: got v=%b err=%b op=%0d data=%h want v=1 err=1 op=%0d data=0",
                         i, tl_d2h.d_valid, tl_d2h.d_error, tl_d2h.d_opcode, tl_d2h.d_data, dops[i]); n_fail++;
            end
            n_checks++;
            $display("tx bad request op=%0d addr=%h size=%0d d_error=%b", ops[i], addrs[i], sizes[i], tl_d2h.d_error);
            tick();
        end
    endtask

    task automatic test_reg_error();
        reg_ready_i = 1'b1;
        reg_error_i = 1'b1;
        tl_h2d.d_ready = 1'b1;
        drive_req(PutFullData, 32'h30, 2'd2, 8'h07, 4'hF, 32'h01020304);
        tick();
        tl_h2d.a_valid = 1'b0;
        if (reg_we_o !== 1'b1) begin $display("FAIL regerr_strobe: got %b want 1", reg_we_o); n_fail++; end
        n_checks++;
        tick();
        reg_error_i = 1'b0;
        if ({tl_d2h.d_valid, tl_d2h.d_error, tl_d2h.d_opcode} !== {1'b1, 1'b1, 3'd0}) begin
            $display("FAIL regerr_resp: got v=%b err=%b op=%0d want v=1 err=1 op=0", tl_d2h.d_valid, tl_d2h.d_error, tl_d2h.d_opcode);
            n_fail++;
        end
        n_checks++;
        $display("tx write addr=30 with register error d_error=%b", tl_d2h.d_error);
        tick();
    endtask

    task automatic test_back_to_back();
        reg_ready_i = 1'b1;
        reg_rdata_i = 32'h0BADF00D;
        tl_h2d.d_ready = 1'b0;
        drive_req(Get, 32'h40, 2'd2, 8'h11, 4'hF, 32'h0);
        tick();
        drive_req(PutFullData, 32'h44, 2'd2, 8'h22, 4'hF, 32'h11223344);
        if (tl_d2h.a_ready !== 1'b0) begin $display("FAIL b2b_a_ready_access: got %b want 0", tl_d2h.a_ready); n_fail++; end
        n_checks++;
        tick();
        for (int i = 0; i < 5; i++) begin
            if ({tl_d2h.d_valid, tl_d2h.d_opcode, tl_d2h.d_source, tl_d2h.d_data, tl_d2h.d_error} !== {1'b1, 3'd1, 8'h11, 32'h0BADF00D, 1'b0}) begin
                $display("FAIL b2b_hold_c%0d: got v=%b op=%0d src=%h data=%h err=%b want v=1 op=1 src=11 data=0badf00d err=0",
                         i, tl_d2h.d_valid, tl_d2h.d_opcode, tl_d2h.d_source, tl_d2h.d_data, tl_d2h.d_error); n_fail++;
            end
            n_checks++;
            if ({tl_d2h.a_ready, reg_re_o, reg_we_o} !== 3'b000) begin
                $display("FAIL b2b_quiet_c%0d: got a_ready/re/we %b want 000", i, {tl_d2h.a_ready, reg_re_o, reg_we_o}); n_fail++;
            end
            n_checks++;
            tick();
        end
        tl_h2d.d_ready = 1'b1;
        $display("tx read addr=40 held 5 cycles d_data=%h", tl_d2h.d_data);
        tick();
        if (tl_d2h.a_ready !== 1'b1) begin $display("FAIL b2b_a_ready_after: got %b want 1", tl_d2h.a_ready); n_fail++; end
        n_checks++;
        tick();
        tl_h2d.a_valid = 1'b0;
        if ({reg_we_o, reg_addr_o, reg_wdata_o} !== {1'b1, 8'h44, 32'h11223344}) begin
            $display("FAIL b2b_second_access: got we=%b addr=%h wdata=%h want 1 44 11223344", reg_we_o, reg_addr_o, reg_wdata_o);
            n_fail++;
        end
        n_checks++;
        tick();
        if ({tl_d2h.d_valid, tl_d2h.d_opcode, tl_d2h.d_source} !== {1'b1, 3'd0, 8'h22}) begin
            $display("FAIL b2b_second_resp: got v=%b op=%0d src=%h want 1 0 22", tl_d2h.d_valid, tl_d2h.d_opcode, tl_d2h.d_source);
            n_fail++;
        end
        n_checks++;
        $display("tx write addr=44 back-to-back src=%h", tl_d2h.d_source);
        for (int i = 0; i < 3; i++) begin
            tick();
            if ({tl_d2h.d_valid, reg_re_o, reg_we_o} !== 3'b000) begin
                $display("FAIL b2b_no_dup_c%0d: got d_valid/re/we %b want 000", i, {tl_d2h.d_valid, reg_re_o, reg_we_o}); n_fail++;
            end
            n_checks++;
        end
    endtask

    task automatic test_reset_mid();
        reg_ready_i = 1'b0;
        tl_h2d.d_ready = 1'b1;
        drive_req(Get, 32'h50, 2'd2, 8'h33, 4'hF, 32'h0);
        tick();
        tl_h2d.a_valid = 1'b0;
        if (reg_re_o !== 1'b1) begin $display("FAIL rstmid_pre_strobe: got %b want 1", reg_re_o); n_fail++; end
        n_checks++;
        #2 rst_ni = 1'b0;
        #1;
        if ({reg_re_o, tl_d2h.d_valid, tl_d2h.a_ready, reg_addr_o} !== 11'h0) begin
            $display("FAIL rstmid_access: got re=%b d_valid=%b a_ready=%b addr=%h want all 0",
                     reg_re_o, tl_d2h.d_valid, tl_d2h.a_ready, reg_addr_o); n_fail++;
        end
        n_checks++;
        tick();
        rst_ni = 1'b1;
        reg_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if ({tl_d2h.d_valid, reg_re_o, tl_d2h.a_ready} !== 3'b001) begin
                $display("FAIL rstmid_no_resp_c%0d: got d_valid/re/a_ready %b want 001", i, {tl_d2h.d_valid, reg_re_o, tl_d2h.a_ready});
                n_fail++;
            end
            n_checks++;
        end
        $display("tx read addr=50 aborted by reset in ACCESS");
        reg_rdata_i = 32'h55AA55AA;
        tl_h2d.d_ready = 1'b0;
        drive_req(Get, 32'h54, 2'd2, 8'h34, 4'hF, 32'h0);
        tick();
        tl_h2d.a_valid = 1'b0;
        tick();
        if (tl_d2h.d_valid !== 1'b1) begin $display("FAIL rstmid_resp_pre: got %b want 1", tl_d2h.d_valid); n_fail++; end
        n_checks++;
        #2 rst_ni = 1'b0;
        #1;
        if ({tl_d2h.d_valid, tl_d2h.d_error, tl_d2h.d_data} !== 34'h0) begin
            $display("FAIL rstmid_resp: got d_valid=%b err=%b data=%h want 0", tl_d2h.d_valid, tl_d2h.d_error, tl_d2h.d_data);
            n_fail++;
        end
        n_checks++;
        tick();
        rst_ni = 1'b1;
        tl_h2d.d_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (tl_d2h.d_valid !== 1'b0) begin $display("FAIL rstmid_resp_after_c%0d: got %b want 0", i, tl_d2h.d_valid); n_fail++; end
            n_checks++;
        end
        $display("tx read addr=54 aborted by reset in RESP");
    endtask

    task automatic test_timeout();
        reg_ready_i = 1'b0;
        reg_rdata_i = 32'hFFFFFFFF;
        tl_h2d.d_ready = 1'b1;
        drive_req(Get, 32'h60, 2'd2, 8'h66, 4'hF, 32'h0);
        tick();
        tl_h2d.a_valid = 1'b0;
`ifdef TLUL_REG_BRIDGE_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            if ({reg_re_o, tl_d2h.d_valid} !== 2'b10) begin
                $display("FAIL to_wait_c%0d: got re/d_valid %b want 10", i, {reg_re_o, tl_d2h.d_valid}); n_fail++;
            end
            n_checks++;
            tick();
        end
        if ({reg_re_o, tl_d2h.d_valid, tl_d2h.d_error, tl_d2h.d_data} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
            $display("FAIL to_resp: got re=%b v=%b err=%b data=%h want 0 1 1 0", reg_re_o, tl_d2h.d_valid, tl_d2h.d_error, tl_d2h.d_data);
            n_fail++;
        end
        n_checks++;
        $display("tx read addr=60 timed out d_error=%b", tl_d2h.d_error);
        tick();
`else
        for (int i = 0; i < 40; i++) begin
            if ({reg_re_o, tl_d2h.d_valid} !== 2'b10) begin
                $display("FAIL nto_wait_c%0d: got re/d_valid %b want 10", i, {reg_re_o, tl_d2h.d_valid}); n_fail++;
            end
            n_checks++;
            tick();
        end
        reg_ready_i = 1'b1;
        reg_rdata_i = 32'h600D600D;
        tick();
        if ({tl_d2h.d_valid, tl_d2h.d_error, tl_d2h.d_data} !== {1'b1, 1'b0, 32'h600D600D}) begin
            $display("FAIL nto_resp: got v=%b err=%b data=%h want 1 0 600d600d", tl_d2h.d_valid, tl_d2h.d_error, tl_d2h.d_data);
            n_fail++;
        end
        n_checks++;
        $display("tx read addr=60 waited 40 cycles then completed d_data=%h", tl_d2h.d_data);
        tick();
`endif
        if (tl_d2h.a_ready !== 1'b1) begin $display("FAIL to_idle: got %b want 1", tl_d2h.a_ready); n_fail++; end
        n_checks++;
    endtask

    initial begin
        rst_ni      = 1'b0;
        tl_h2d      = '0;
        reg_rdata_i = '0;
        reg_ready_i = 1'b0;
        reg_error_i = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_errors();
        test_reg_error();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tlul_reg_bridge.md
TLUL_REG_BRIDGE -- requirements
Module: tlul_reg_bridge

Interface
REQ-001 SHALL have parameter AW, default 8, meaning register address width in bits.
REQ-002 SHALL have parameter TimeoutCycles, default 16, meaning the ACCESS-state wait limit used only under REQ-030.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port tl_i, input, tlul_pkg::tl_h2d_t: TL-UL request from one xbar_periph device port.
REQ-006 SHALL have port tl_o, output, tlul_pkg::tl_d2h_t: TL-UL response to xbar_periph.
REQ-007 SHALL have port reg_re_o, output, 1 bit: register read strobe.
REQ-008 SHALL have port reg_we_o, output, 1 bit: register write strobe.
REQ-009 SHALL have port reg_addr_o, output, AW bits: byte address, equal to a_address[AW-1:0] with bits [1:0] forced to 0.
REQ-010 SHALL have ports reg_wdata_o (output, 32 bits) and reg_be_o (output, 4 bits): write data and byte enables, taken from a_data and a_mask.
REQ-011 SHALL have port reg_rdata_i, input, 32 bits: read data, sampled when reg_ready_i=1.
REQ-012 SHALL have port reg_ready_i, input, 1 bit: register block completes the access this cycle.
REQ-013 SHALL have port reg_error_i, input, 1 bit: register block flags an error, sampled when reg_ready_i=1.

Function
REQ-014 SHALL implement an FSM with states IDLE, ACCESS and RESP, one transaction in flight at a time.
REQ-015 SHALL drive a_ready=1 only in IDLE; a request is accepted when a_valid=1 and a_ready=1.
REQ-016 On accept, SHALL latch a_opcode, a_size, a_source, a_address, a_mask and a_data.
REQ-017 Supported opcodes: Get (4) maps to read; PutFullData (0) and PutPartialData (1) map to write.
REQ-018 If the accepted opcode is unsupported, a_address[1:0]!=0, or a_size>2, SHALL go IDLE->RESP with d_error=1, asserting no strobe.
REQ-019 Otherwise, SHALL go IDLE->ACCESS and hold reg_re_o or reg_we_o (exactly one), plus address, data and byte enables, stable until reg_ready_i=1.
REQ-020 In ACCESS with reg_ready_i=1, SHALL capture reg_rdata_i and reg_error_i, drop the strobe next cycle, and go to RESP.
REQ-021 In RESP, SHALL drive d_valid=1 with:
- d_opcode: AccessAckData (1) for reads, AccessAck (0) for writes.
- d_size and d_source: the latched values.
- d_data: captured data for reads, otherwise 0.
- d_error: per REQ-018 or REQ-020.
REQ-022 SHALL hold all d_* fields stable while d_valid=1 and d_ready=0, and go RESP->IDLE on d_ready=1.
REQ-023 Minimum latency: accept in cycle N, strobe in N+1 (with reg_ready_i=1), d_valid in N+2, a_ready again in N+3.
REQ-024 A request presented while not in IDLE SHALL be ignored (a_ready=0); no request SHALL be lost or duplicated.
REQ-025 d_param and d_sink SHALL be 0; d_user SHALL be the tlul_pkg default.

Reset
REQ-026 On rst_ni=0 (asynchronous), the FSM SHALL enter IDLE.
REQ-027 During reset, all outputs SHALL be 0 (a_ready, d_valid, strobes, address, data, d_error), including when reset hits mid-ACCESS or mid-RESP.
REQ-028 After reset release, a_ready SHALL be 1 in the first cycle; no response SHALL be produced for a transaction aborted by reset.

Configuration
REQ-029 Feature macro: TLUL_REG_BRIDGE_TIMEOUT_EN.
REQ-030 With TLUL_REG_BRIDGE_TIMEOUT_EN defined:
- A counter clears on ACCESS entry and increments each ACCESS cycle with reg_ready_i=0.
- When it reaches TimeoutCycles, the FSM SHALL deassert the strobe and go to RESP with d_error=1 and d_data=0.
- reg_ready_i in the same cycle takes priority over the timeout.
REQ-031 Without the macro, SHALL contain no counter and SHALL wait in ACCESS indefinitely.

Verification
REQ-032 Get to 0x10, reg_ready_i=1 immediately, reg_rdata_i=0xDEADBEEF -> reg_re_o for 1 cycle with reg_addr_o=0x10; d_valid at N+2 with d_opcode=1, d_data=0xDEADBEEF, d_error=0.
REQ-033 PutPartialData to 0x24, mask 0x3, data 0x0000A5A5, reg_ready_i delayed 3 cycles -> reg_we_o held 4 cycles with reg_be_o=0x3; then AccessAck with d_error=0 and a_source echoed.
REQ-034 Get to 0x13 (misaligned), and separately opcode 7 -> no strobe; d_error=1 at N+1.
REQ-035 d_ready held 0 for 5 cycles during RESP -> d_* stable; a_ready=0 throughout; back-to-back request accepted the cycle after d_ready=1.
REQ-036 rst_ni pulsed low during ACCESS -> strobe and d_valid drop immediately; no response after release.
REQ-037 With TLUL_REG_BRIDGE_TIMEOUT_EN, reg_ready_i held 0 -> d_error=1 after 16 ACCESS cycles; without the macro, no response is produced.
